obu_header_writer: RTL
======================

OBU_HEADER_WRITER -- requirements
Module: obu_header_writer

Interface
REQ-001 Parameters: none; all widths SHALL come from obu_parser_pkg constants (OBU_SIZE_WIDTH=56, LEB128_MAX_BYTES=8).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to emit one OBU header; accepted only when in_ready=1.
REQ-005 in_ready  output  1  high in IDLE only.
REQ-006 obu_type  input  4  OBU type field.
REQ-007 ext_flag  input  1  emit extension byte.
REQ-008 temporal_id  input  3  extension temporal_id.
REQ-009 spatial_id  input  2  extension spatial_id.
REQ-010 has_size  input  1  emit LEB128 obu_size.
REQ-011 obu_size  input  56  payload size; ignored when has_size=0.
REQ-012 byte_out  output  8  current output byte.
REQ-013 byte_valid  output  1  byte_out valid.
REQ-014 byte_ready  input  1  downstream accepts byte when byte_valid&byte_ready.
REQ-015 byte_last  output  1  byte_out is final byte of this header.
REQ-016 done  output  1  one-cycle pulse the cycle after the last byte transfer.

Function
REQ-017 FSM states SHALL be IDLE, HDR, EXT, SIZE; start&in_ready latches all input fields and moves IDLE->HDR next cycle.
REQ-018 HDR byte SHALL be {1'b0, obu_type, ext_flag, has_size, 1'b0} (bit 7 first listed).
REQ-019 EXT byte SHALL be {temporal_id, spatial_id, 3'b000}.
REQ-020 SIZE bytes SHALL be minimal LEB128 of obu_size: low 7 bits first, bit 7 = 1 on every byte except the last; obu_size=0 emits single 0x00.
REQ-021 Transitions on transfer only: HDR->EXT if ext_flag, else ->SIZE if has_size, else ->IDLE; EXT->SIZE if has_size else ->IDLE; SIZE->IDLE after final LEB byte.
REQ-022 byte_last SHALL be high with exactly the final byte; byte_valid high in HDR, EXT, SIZE only.
REQ-023 While byte_valid=1 and byte_ready=0, byte_out, byte_valid, byte_last SHALL hold stable.
REQ-024 Throughput SHALL be one byte per cycle under continuous byte_ready; first byte valid one cycle after start accepted.
REQ-025 start while in_ready=0 SHALL be ignored; input field changes after acceptance SHALL not affect the header in flight.
REQ-026 LEB128 byte count SHALL be 1..8; obu_size=2^56-1 emits 8 bytes.
REQ-027 done SHALL assert in the cycle following the byte_last transfer, concurrent with in_ready=1; a start in that cycle SHALL be accepted.

Reset
REQ-028 rst_n low SHALL force IDLE, byte_valid=0, byte_last=0, done=0, byte_out=0x00, in_ready=1 (in_ready=1 on first cycle after release).
REQ-029 Reset mid-header SHALL abandon the header; no further bytes of it appear after rst_n rises.

Structure
REQ-030 OBU_SIZE_WIDTH, LEB128_MAX_BYTES, and a packed obu_header_t struct (type, ext_flag, temporal_id, spatial_id, has_size, obu_size) SHALL live in obu_parser_pkg, shared with the header parser.
REQ-031 LEB128 serialisation SHALL be a sub-module leb128_encoder (load value, emit 7-bit groups with continuation flag, advance on transfer, flag last byte).

Verification
REQ-032 type=1, ext=0, has_size=1, size=0 -> bytes 0x0A, 0x00; last on 2nd; done next cycle.
REQ-033 type=6, ext=1, tid=2, sid=1, has_size=1, size=300 -> 0x36, 0x48, 0xAC, 0x02.
REQ-034 type=2, ext=0, has_size=0, size=0xFFFF -> single byte 0x10 with byte_last; size ignored.
REQ-035 size=2^56-1, byte_ready toggled randomly -> 0x?? hdr, then 0xFF x7, 0x7F; outputs stable while stalled.
REQ-036 rst_n pulsed during SIZE byte 2 of size=300 -> byte_valid=0 immediately; next start emits a fresh, correct header.
REQ-037 Back-to-back starts on done cycle -> zero idle gap beyond one cycle, both headers correct.

Source files
------------

// File: rtl/obu_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obu_parser_pkg
// Description : Shared constants and types for the OBU header writer/parser.
//               OBU_SIZE_WIDTH    - width of the obu_size field (bits)
//               LEB128_MAX_BYTES  - longest LEB128 encoding of obu_size
//               obu_header_t      - latched header fields
//               Helper functions build the fixed header and extension bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package obu_parser_pkg;

    localparam int OBU_SIZE_WIDTH   = 56;
    localparam int LEB128_MAX_BYTES = 8;

    typedef struct packed {
        logic [3:0]                obu_type;
        logic                      ext_flag;
        logic [2:0]                temporal_id;
        logic [1:0]                spatial_id;
        logic                      has_size;
        logic [OBU_SIZE_WIDTH-1:0] obu_size;
    } obu_header_t;

    // Bit 7 is the forbidden bit, bit 0 is reserved; both are always zero.
    function automatic logic [7:0] obu_hdr_byte(input obu_header_t h);
        return {1'b0, h.obu_type, h.ext_flag, h.has_size, 1'b0};
    endfunction

    function automatic logic [7:0] obu_ext_byte(input obu_header_t h);
        return {h.temporal_id, h.spatial_id, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/leb128_encoder.sv
`default_nettype none
// ============================================================================
// Module      : leb128_encoder
// Description : Serialises a value as minimal LEB128, one byte per advance.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_value as the value to serialise
//   load_value  : value to encode
//   advance     : current byte was consumed, move to the next 7-bit group
//   leb_byte    : current encoded byte (continuation flag in bit 7)
//   leb_last    : current byte is the final byte of the encoding
// Revision    : 1.0 - initial release
// ============================================================================
module leb128_encoder
    import obu_parser_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [OBU_SIZE_WIDTH-1:0] load_value,
    input  logic                      advance,
    output logic [7:0]                leb_byte,
    output logic                      leb_last
);

    // Remaining bits still to be sent; the low 7 bits form the current byte.
    logic [OBU_SIZE_WIDTH-1:0] r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
        end else if (load) begin
            r_rem <= load_value;
        end else if (advance) begin
            r_rem <= r_rem >> 7;
        end
    end

    // Last byte once nothing remains above the current 7-bit group. A zero
    // value therefore yields exactly one 0x00 byte, and a 56-bit value never
    // needs more than eight groups.
    assign leb_last = (r_rem[OBU_SIZE_WIDTH-1:7] == '0);
    assign leb_byte = {~leb_last, r_rem[6:0]};

endmodule
`default_nettype wire

// File: rtl/obu_header_writer.sv
`default_nettype none
// ============================================================================
// Module      : obu_header_writer
// Description : Emits one OBU header as a byte stream: header byte, optional
//               extension byte, optional LEB128 obu_size.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / in_ready    : header request handshake (in_ready high in IDLE)
//   obu_type, ext_flag, temporal_id, spatial_id, has_size, obu_size
//                       : header fields, captured when start is accepted
//   byte_out/byte_valid/byte_ready/byte_last
//                       : output byte stream with valid/ready handshake
//   done                : one-cycle pulse after the final byte transfer
// Revision    : 1.0 - initial release
// ============================================================================
module obu_header_writer
    import obu_parser_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      in_ready,
    input  logic [3:0]                obu_type,
    input  logic                      ext_flag,
    input  logic [2:0]                temporal_id,
    input  logic [1:0]                spatial_id,
    input  logic                      has_size,
    input  logic [OBU_SIZE_WIDTH-1:0] obu_size,
    output logic [7:0]                byte_out,
    output logic                      byte_valid,
    input  logic                      byte_ready,
    output logic                      byte_last,
    output logic                      done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_EXT  = 2'd2;
    localparam logic [1:0] ST_SIZE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    obu_header_t r_hdr;
    logic        r_done;

    logic        w_accept;
    logic        w_xfer;
    logic [7:0]  w_leb_byte;
    logic        w_leb_last;

    assign w_accept = start & in_ready;
    assign w_xfer   = byte_valid & byte_ready;
    assign done     = r_done;

    // Field capture: everything after acceptance is ignored until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr <= '0;
        end else if (w_accept) begin
            r_hdr.obu_type    <= obu_type;
            r_hdr.ext_flag    <= ext_flag;
            r_hdr.temporal_id <= temporal_id;
            r_hdr.spatial_id  <= spatial_id;
            r_hdr.has_size    <= has_size;
            r_hdr.obu_size    <= has_size ? obu_size : '0;
        end
    end

    // The encoder is (re)loaded from the captured size for as long as the
    // header byte is pending; it only starts advancing once in SIZE.
    leb128_encoder u_leb128 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (r_state == ST_HDR),
        .load_value (r_hdr.obu_size),
        .advance    (w_xfer && (r_state == ST_SIZE)),
        .leb_byte   (w_leb_byte),
        .leb_last   (w_leb_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: header states only move on a byte transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    if (r_hdr.ext_flag) begin
                        w_state_next = ST_EXT;
                    end else if (r_hdr.has_size) begin
                        w_state_next = ST_SIZE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_EXT: begin
                if (w_xfer) begin
                    w_state_next = r_hdr.has_size ? ST_SIZE : ST_IDLE;
                end
            end
            ST_SIZE: begin
                if (w_xfer && w_leb_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: depends only on registered state, so outputs stay
    // stable for as long as the downstream stalls.
    always_comb begin
        in_ready   = 1'b0;
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        byte_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_HDR: begin
                byte_valid = 1'b1;
                byte_out   = obu_hdr_byte(r_hdr);
                byte_last  = ~r_hdr.ext_flag & ~r_hdr.has_size;
            end
            ST_EXT: begin
                byte_valid = 1'b1;
                byte_out   = obu_ext_byte(r_hdr);
                byte_last  = ~r_hdr.has_size;
            end
            ST_SIZE: begin
                byte_valid = 1'b1;
                byte_out   = w_leb_byte;
                byte_last  = w_leb_last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_xfer & byte_last;
        end
    end

endmodule
`default_nettype wire
